wave_capture: RTL
=================

Name: wave_capture

Overview:
- Writer side of the double-buffered waveform sample RAM that the wave display reads.
- Watches the codec sample stream and arms on a rising zero crossing.
- Writes 256 consecutive 8-bit display samples into the RAM half the display is not reading.
- Waits for the display to go idle, then flips read_index so the display switches to the fresh half.

Parameters:
- SAMPLE_WIDTH, 16, width of the signed two's-complement input sample.
- DISPLAY_WIDTH, 8, width of the sample written to RAM.
- HALF_DEPTH_LOG2, 8, log2 of samples per RAM half (256). RAM address width is HALF_DEPTH_LOG2+1 = 9.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  16  signed audio sample.
- wave_display_idle  input  1  high while the display is outside the visible wave region (safe to swap halves).
- write_address  output  9  RAM write address: {half, offset[7:0]}.
- write_enable  output  1  one-cycle RAM write strobe.
- write_sample  output  8  offset-binary display sample.
- read_index  output  1  RAM half the display reads. The writer always targets ~read_index.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. All state and outputs are registered.
- Reset values:
  - state = ARMED, offset counter = 0, prev_sample = 0.
  - read_index = 0, write_enable = 0, write_address = 0, write_sample = 0.
- Sample conversion: write_sample = {~s[15], s[14:8]}, i.e. the top 8 bits with the MSB inverted.
  - 16'h8000 -> 8'h00.
  - 16'h0000 -> 8'h80.
  - 16'h7FFF -> 8'hFF.
- prev_sample updates to new_sample_in on every new_sample_ready, in every state.
- Rising crossing: new_sample_ready high AND prev_sample[15] = 1 AND new_sample_in[15] = 0.
- State ARMED:
  - On a rising crossing, the crossing sample is written at offset 0.
  - Counter becomes 1; go to ACTIVE.
  - Otherwise there are no writes.
- State ACTIVE:
  - Each new_sample_ready writes that sample at the current counter value, then the counter increments.
  - The write of offset 255 transitions to WAIT and clears the counter to 0.
  - Crossings are ignored in ACTIVE.
- State WAIT:
  - No writes.
  - When wave_display_idle = 1: toggle read_index and go to ARMED.
  - A new_sample_ready in the same cycle only updates prev_sample; no crossing is evaluated that cycle.
- Write timing:
  - For a sample accepted in cycle N, write_enable = 1 in cycle N+1 only.
  - write_address = {~read_index (value at cycle N), offset}; write_sample is the converted sample.
  - The target half is latched at acceptance, so the read_index flip never retargets an in-flight write.
- Back-to-back new_sample_ready on consecutive cycles is supported: one write per cycle, no drops.
- new_sample_ready with no state-qualified action: write_enable stays 0.
- Reset mid-capture: partial buffer abandoned, read_index returns to 0, no spurious write after release.
- wave_display_idle held high outside WAIT has no effect.
- Exactly one flip per completed capture.

Decomposition:
- Shared package (wave_pkg), consumed by this block and the display:
  - State encodings: ARMED = 2'd0, ACTIVE = 2'd1, WAIT = 2'd2.
  - HALF_DEPTH = 256 and the RAM address width.
  - The DISPLAY_WIDTH constant.
- One sub-module: sample_zero_cross.
  - Holds prev_sample and emits the registered-compare rising_crossing pulse.
  - Reusable by a future trigger-level option.
- The remaining FSM, counter and output registers live in wave_capture.

Test Plan:
1. Reset held 3 cycles, then released.
   - No strobes -> write_enable = 0, read_index = 0, write_address = 0 for 20 cycles.
2. Arm and trigger: feed -100 (16'hFF9C) then +50 (16'h0032).
   - -> one cycle after the +50 strobe: write_enable = 1, write_address = 9'h100, write_sample = 8'h80.
   - The next 255 strobes write addresses 9'h101..9'h1FF in order; then writes stop.
3. With a capture complete, hold wave_display_idle = 0 for 50 cycles, then pulse it for 1 cycle.
   - -> read_index stays 0 throughout, becomes 1 the cycle after the pulse.
   - The next capture writes 9'h000..9'h0FF.
4. Conversion: during ACTIVE feed 16'h8000, 16'h7FFF, 16'h0000.
   - -> write_sample 8'h00, 8'hFF, 8'h80.
5. Negative-to-negative and positive-to-positive sequences (-5, -3, 4, 7 after a completed capture in ARMED, with 4 the only crossing).
   - -> the only trigger is on 4, at offset 0.
   - A sequence of non-negative values only (0, 1, 2) -> no writes.
6. Assert reset while the counter = 100 in ACTIVE.
   - -> write_enable low immediately, read_index = 0.
   - After release, the first -1 then +1 pair restarts at offset 0 of half 1.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the double-buffered waveform RAM, used by the
// capture writer and the wave display reader.
package wave_pkg;

  localparam int SAMPLE_WIDTH    = 16;
  localparam int DISPLAY_WIDTH   = 8;
  localparam int HALF_DEPTH_LOG2 = 8;
  localparam int HALF_DEPTH      = 1 << HALF_DEPTH_LOG2;
  localparam int ADDR_WIDTH      = HALF_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } capture_state_t;

endpackage

// File: rtl/sample_zero_cross.sv
// Keeps the previous accepted sample and flags a rising (negative to
// non-negative) zero crossing on the current strobe.
module sample_zero_cross #(
  parameter int SAMPLE_WIDTH = wave_pkg::SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  output logic                    rising_crossing
);

  logic [SAMPLE_WIDTH-1:0] prev_sample;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample <= '0;
    end else if (new_sample_ready) begin
      prev_sample <= new_sample_in;
    end
  end

  // Compare against the registered previous sample so the crossing is
  // known in the same cycle the new sample is accepted.
  assign rising_crossing = new_sample_ready
                         & prev_sample[SAMPLE_WIDTH-1]
                         & ~new_sample_in[SAMPLE_WIDTH-1];

endmodule

// File: rtl/wave_capture.sv
// Writer side of the double-buffered wave RAM: arms on a rising zero
// crossing, fills the idle half with 256 samples, then swaps halves.
module wave_capture
  import wave_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = wave_pkg::SAMPLE_WIDTH,
  parameter int DISPLAY_WIDTH   = wave_pkg::DISPLAY_WIDTH,
  parameter int HALF_DEPTH_LOG2 = wave_pkg::HALF_DEPTH_LOG2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]    new_sample_in,
  input  logic                       wave_display_idle,
  output logic [HALF_DEPTH_LOG2:0]   write_address,
  output logic                       write_enable,
  output logic [DISPLAY_WIDTH-1:0]   write_sample,
  output logic                       read_index
);

  capture_state_t              state, next_state;
  logic [HALF_DEPTH_LOG2-1:0]  offset, next_offset;
  logic                        next_read_index;
  logic                        next_write_enable;
  logic [HALF_DEPTH_LOG2:0]    next_write_address;
  logic [DISPLAY_WIDTH-1:0]    next_write_sample;
  logic [DISPLAY_WIDTH-1:0]    converted;
  logic                        rising_crossing;

  sample_zero_cross #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_zero_cross (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .rising_crossing  (rising_crossing)
  );

  // Signed to offset-binary: keep the top bits, flip the sign bit.
  assign converted = {~new_sample_in[SAMPLE_WIDTH-1],
                      new_sample_in[SAMPLE_WIDTH-2 -: DISPLAY_WIDTH-1]};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state         = state;
    next_offset        = offset;
    next_read_index    = read_index;
    next_write_enable  = 1'b0;
    next_write_address = write_address;
    next_write_sample  = write_sample;
    unique case (state)
      ARMED: begin
        if (rising_crossing) begin
          next_write_enable  = 1'b1;
          next_write_address = {~read_index, {HALF_DEPTH_LOG2{1'b0}}};
          next_write_sample  = converted;
          next_offset        = HALF_DEPTH_LOG2'(1);
          next_state         = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          next_write_enable  = 1'b1;
          next_write_address = {~read_index, offset};
          next_write_sample  = converted;
          next_offset        = offset + HALF_DEPTH_LOG2'(1);
          if (offset == {HALF_DEPTH_LOG2{1'b1}}) begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          next_read_index = ~read_index;
          next_state      = ARMED;
        end
      end
      default: next_state = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARMED;
      offset        <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      state         <= next_state;
      offset        <= next_offset;
      read_index    <= next_read_index;
      write_enable  <= next_write_enable;
      write_address <= next_write_address;
      write_sample  <= next_write_sample;
    end
  end

endmodule
